// File: rtl/clock_counter_pkg.sv
// Shared constants for the clock counter host and the counter it commands:
// opcodes, register addresses and the host FSM encoding.
package clock_counter_pkg;

  localparam logic [1:0] OP_CLEAR   = 2'd0;
  localparam logic [1:0] OP_START   = 2'd1;
  localparam logic [1:0] OP_STOP    = 2'd2;
  localparam logic [1:0] OP_ILLEGAL = 2'd3;

  localparam logic [1:0] REG_CMD    = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_WRAPS  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_SETTLE,
    ST_RDWAIT
  } state_e;

endpackage

// File: rtl/clock_counter_host.sv
// Avalon-MM slave that turns CPU register writes into one-cycle command pulses
// for the negedge clock counter, and tracks running state and count wraps.
module clock_counter_host
  import clock_counter_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic             read,
  output logic [31:0]      readdata,
  output logic             waitrequest,
  output logic             cnt_enable,
  output logic [CNT_W-1:0] cnt_command,
  input  logic [CNT_W-1:0] cnt_count
);

  localparam logic [1:0] SETTLE_INIT = 2'(SETTLE);

  state_e           state, state_nxt;
  logic [1:0]       settle_cnt;
  logic [1:0]       last_op;
  logic             running, err, wrap;
  logic [CNT_W-1:0] snapshot;
  logic [CNT_W-1:0] prev_count;
  logic [31:0]      wrap_cnt;

  logic [1:0]       wr_op, cmd_op;
  logic             cmd_wr, cmd_legal, cnt_rd, status_wr, clear_window, busy;
  logic [31:0]      reg_mux;
  logic             unused_wdata;

  assign wr_op        = writedata[1:0];
  assign cmd_op       = cnt_command[1:0];
  assign cmd_wr       = write && (address == REG_CMD);
  assign cmd_legal    = cmd_wr && (wr_op != OP_ILLEGAL);
  assign status_wr    = write && (address == REG_STATUS);
  // A read issued together with a write is treated as not issued.
  assign cnt_rd       = read && !write && (address == REG_COUNT);
  assign busy         = (state != ST_IDLE);
  // The counter's own clear produces a downward step that is not a wrap.
  assign clear_window = ((state == ST_PULSE) || (state == ST_SETTLE)) && (cmd_op == OP_CLEAR);
  // Decoded from state so an asynchronous reset drops the pulse immediately.
  assign cnt_enable   = (state == ST_PULSE);
  assign unused_wdata = ^writedata[31:3];

  always_comb begin
    reg_mux = '0;
    case (address)
      REG_CMD:    reg_mux = {29'b0, busy, last_op};
      REG_COUNT:  reg_mux = 32'(snapshot);
      REG_WRAPS:  reg_mux = wrap_cnt;
      REG_STATUS: reg_mux = {29'b0, wrap, err, running};
      default:    reg_mux = '0;
    endcase
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    waitrequest = 1'b0;
    readdata    = '0;
    case (state)
      ST_IDLE: begin
        if (cmd_legal) begin
          state_nxt   = ST_PULSE;
          waitrequest = 1'b1;
        end else if (cnt_rd) begin
          state_nxt   = ST_RDWAIT;
          waitrequest = 1'b1;
        end else if (read && !write) begin
          readdata = reg_mux;
        end
      end
      ST_PULSE: begin
        state_nxt   = ST_SETTLE;
        waitrequest = 1'b1;
      end
      ST_SETTLE: begin
        if (settle_cnt == 2'd0) state_nxt = ST_IDLE;
        else                    waitrequest = 1'b1;
      end
      ST_RDWAIT: begin
        readdata  = 32'(snapshot);
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      settle_cnt  <= '0;
      cnt_command <= '0;
      last_op     <= OP_CLEAR;
      running     <= 1'b0;
      err         <= 1'b0;
      wrap        <= 1'b0;
      snapshot    <= '0;
      prev_count  <= '0;
      wrap_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      prev_count <= cnt_count;

      case (state)
        ST_IDLE: begin
          if (cmd_legal)   cnt_command <= CNT_W'(wr_op);
          else if (cmd_wr) err <= 1'b1;
          if (status_wr && writedata[1]) err  <= 1'b0;
          if (status_wr && writedata[2]) wrap <= 1'b0;
          if (cnt_rd) snapshot <= cnt_count;
        end
        ST_PULSE: begin
          settle_cnt <= SETTLE_INIT;
          last_op    <= cmd_op;
          if (cmd_op == OP_START) running <= 1'b1;
          if (cmd_op == OP_STOP)  running <= 1'b0;
        end
        ST_SETTLE: begin
          if (settle_cnt != 2'd0) settle_cnt <= settle_cnt - 2'd1;
        end
        default: ;
      endcase

      // A wrap event wins over a same-cycle software clear of the flag.
      if (running && !clear_window && (cnt_count < prev_count)) begin
        wrap <= 1'b1;
        if (wrap_cnt != '1) wrap_cnt <= wrap_cnt + 32'd1;
      end
      if ((state == ST_PULSE) && (cmd_op == OP_CLEAR)) wrap_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_clock_counter_host.sv
// Scoreboard bench for clock_counter_host driving a behavioural negedge
// counter; read responses are checked by a monitor against queued expectations.
module tb_clock_counter_host;
  import clock_counter_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic        read = 1'b0;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        cnt_enable;
  logic [31:0] cnt_command;
  logic [31:0] cnt_count;

  always #5 clk = ~clk;

  clock_counter_host #(.CNT_W(32), .SETTLE(1)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .write(write),
    .writedata(writedata), .read(read), .readdata(readdata),
    .waitrequest(waitrequest), .cnt_enable(cnt_enable),
    .cnt_command(cnt_command), .cnt_count(cnt_count)
  );

  // Behavioural counter: acts on enable and counts on falling edges.
  logic [31:0] model_count;
  logic        model_run;
  logic [31:0] preload_val = '0;
  int          preload_seq = 0;
  int          preload_ack = 0;
  int          pulse_cnt = 0;
  logic [31:0] pulse_cmd = '0;

  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_count <= '0;
      model_run   <= 1'b0;
    end else if (preload_seq != preload_ack) begin
      model_count <= preload_val;
      preload_ack <= preload_seq;
    end else if (cnt_enable) begin
      case (cnt_command[1:0])
        OP_CLEAR: model_count <= '0;
        OP_START: model_run   <= 1'b1;
        OP_STOP:  model_run   <= 1'b0;
        default:  ;
      endcase
    end else if (model_run) begin
      model_count <= model_count + 32'd1;
    end
  end
  assign cnt_count = model_count;

  always @(negedge clk) begin
    if (reset_n && cnt_enable) begin
      pulse_cnt <= pulse_cnt + 1;
      pulse_cmd <= cnt_command;
    end
  end

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] last_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a read completes when it is presented alone and not stalled.
  always @(negedge clk) begin
    if (reset_n && read && !write && !waitrequest) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_read: got 0x%08h with no expectation queued", readdata);
      end else begin
        check(name_q.pop_front(), readdata, exp_q.pop_front());
      end
      last_rd <= readdata;
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, output int waits);
    @(posedge clk); #1;
    address = a; writedata = d; write = 1'b1; waits = 0;
    @(negedge clk); #1;
    while (waitrequest && waits < 50) begin
      waits++;
      @(negedge clk); #1;
    end
    if (waitrequest) begin
      tests++; fails++;
      $display("FAIL write_timeout: waitrequest still 1 after %0d cycles", waits);
    end
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input string name, input logic [31:0] exp,
                          input bit from_model, output int waits);
    if (!from_model) begin
      exp_q.push_back(exp);
      name_q.push_back(name);
    end
    @(posedge clk); #1;
    address = a; read = 1'b1; waits = 0;
    @(negedge clk); #1;
    // COUNT is captured at the next rising edge, after this falling edge.
    if (from_model) begin
      exp_q.push_back(model_count);
      name_q.push_back(name);
    end
    while (waitrequest && waits < 50) begin
      waits++;
      @(negedge clk); #1;
    end
    if (waitrequest) begin
      tests++; fails++;
      $display("FAIL read_timeout: waitrequest still 1 after %0d cycles", waits);
    end
    @(posedge clk); #1;
    read = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    int          p0;
    logic [31:0] r1;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_cnt_enable", 32'(cnt_enable), 32'd0);
    check("rst_cnt_command", cnt_command, 32'd0);
    check("rst_waitrequest", 32'(waitrequest), 32'd0);
    check("rst_readdata", readdata, 32'd0);
    @(negedge clk); reset_n = 1'b1;

    // Reset in the middle of a START pulse.
    @(posedge clk); #1;
    address = REG_CMD; writedata = 32'd1; write = 1'b1;
    @(posedge clk); #2;
    check("midpulse_enable_high", 32'(cnt_enable), 32'd1);
    reset_n = 1'b0; write = 1'b0; read = 1'b1; address = REG_STATUS;
    #1;
    check("abort_cnt_enable", 32'(cnt_enable), 32'd0);
    check("abort_waitrequest", 32'(waitrequest), 32'd0);
    check("abort_status", readdata, 32'd0);
    check("abort_cnt_command", cnt_command, 32'd0);
    read = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check("abort_no_pulse_seen", 32'(pulse_cnt), 32'd0);

    // START: one enable cycle, three wait cycles.
    p0 = pulse_cnt;
    bus_write(REG_CMD, 32'd1, w);
    check("start_waits", 32'(w), 32'd3);
    check("start_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("start_pulse_cmd", pulse_cmd, 32'd1);

    // COUNT about 100 cycles after START, one wait cycle.
    repeat (96) @(posedge clk);
    bus_read(REG_COUNT, "count_after_start", 32'd0, 1'b1, w);
    check("count_waits", 32'(w), 32'd1);
    check("count_in_range", 32'(last_rd >= 32'd97 && last_rd <= 32'd103), 32'd1);
    bus_read(REG_STATUS, "status_running", 32'h1, 1'b0, w);
    check("status_waits", 32'(w), 32'd0);
    bus_read(REG_CMD, "cmd_last_start", 32'h1, 1'b0, w);

    // STOP freezes the count.
    p0 = pulse_cnt;
    bus_write(REG_CMD, 32'd2, w);
    check("stop_waits", 32'(w), 32'd3);
    check("stop_pulses", 32'(pulse_cnt - p0), 32'd1);
    bus_read(REG_COUNT, "count_stopped_a", 32'd0, 1'b1, w);
    r1 = last_rd;
    repeat (20) @(posedge clk);
    bus_read(REG_COUNT, "count_stopped_b", 32'd0, 1'b1, w);
    check("count_frozen", last_rd, r1);
    bus_read(REG_STATUS, "status_stopped", 32'h0, 1'b0, w);
    bus_read(REG_CMD, "cmd_last_stop", 32'h2, 1'b0, w);

    // Illegal opcode sets err, no pulse; write-1-to-clear.
    p0 = pulse_cnt;
    bus_write(REG_CMD, 32'd3, w);
    check("illegal_waits", 32'(w), 32'd0);
    check("illegal_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    bus_read(REG_STATUS, "status_err", 32'h2, 1'b0, w);
    bus_write(REG_STATUS, 32'h2, w);
    check("status_wr_waits", 32'(w), 32'd0);
    bus_read(REG_STATUS, "status_err_cleared", 32'h0, 1'b0, w);

    // Writes to COUNT/WRAPS are ignored.
    bus_write(REG_WRAPS, 32'h5, w);
    check("ignored_wr_waits", 32'(w), 32'd0);
    bus_read(REG_WRAPS, "wraps_unchanged", 32'h0, 1'b0, w);

    // Wrap detection from a preloaded counter.
    bus_write(REG_CMD, 32'd0, w);
    bus_write(REG_CMD, 32'd1, w);
    @(posedge clk); #1;
    preload_val = 32'hFFFF_FFF0;
    preload_seq++;
    repeat (30) @(posedge clk);
    bus_read(REG_STATUS, "status_wrapped", 32'h5, 1'b0, w);
    bus_read(REG_WRAPS, "wraps_one", 32'h1, 1'b0, w);
    bus_write(REG_CMD, 32'd0, w);
    bus_read(REG_WRAPS, "wraps_after_clear", 32'h0, 1'b0, w);
    bus_read(REG_STATUS, "status_after_clear", 32'h5, 1'b0, w);

    // Simultaneous read and write: the STOP wins, no read data.
    p0 = pulse_cnt;
    @(posedge clk); #1;
    address = REG_CMD; writedata = 32'd2; write = 1'b1; read = 1'b1; w = 0;
    @(negedge clk); #1;
    while (waitrequest && w < 50) begin
      w++;
      @(negedge clk); #1;
    end
    check("simul_waits", 32'(w), 32'd3);
    check("simul_readdata", readdata, 32'd0);
    @(posedge clk); #1;
    write = 1'b0; read = 1'b0;
    check("simul_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("simul_pulse_cmd", pulse_cmd, 32'd2);
    bus_read(REG_STATUS, "status_simul_stop", 32'h4, 1'b0, w);
    bus_write(REG_STATUS, 32'h4, w);
    bus_read(REG_STATUS, "status_wrap_cleared", 32'h0, 1'b0, w);

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clock_counter_host.md
Name: clock_counter_host

Overview:
- Bus-side controller for the negedge clock counter.
- Presents an Avalon-MM-style slave to the CPU and turns register writes into single-cycle enable/command pulses toward the counter.
- Samples the counter's count output and tracks the running state and 32-bit wrap events.
- Sits between the CPU interconnect and the counter instance. It is the initiator end of the enable/command/count interface.

Parameters:
- CNT_W, 32, width of the counter value and of cnt_command.
- SETTLE, 1, extra cycles waitrequest is held after a command pulse (range 1..3).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  register select.
- write  in  1  bus write strobe.
- writedata  in  32  bus write data.
- read  in  1  bus read strobe.
- readdata  out  32  bus read data.
- waitrequest  out  1  bus stall.
- cnt_enable  out  1  command strobe to the counter.
- cnt_command  out  CNT_W  command code to the counter.
- cnt_count  in  CNT_W  counter value; changes on falling edges, so it is stable at rising edges.

Behaviour:
- Reset (async, reset_n=0) values:
  - Outputs: readdata=0, waitrequest=0, cnt_enable=0, cnt_command=0.
  - Internal: running=0, err=0, wrap=0, snapshot=0, wrap_cnt=0.
  - FSM returns to IDLE. A pulse in flight is aborted; cnt_enable drops immediately.
- Register map:
  - 0 CMD (W): writedata[1:0] opcode; 0 CLEAR, 1 START, 2 STOP, 3 illegal.
  - 0 CMD (R): {29'b0, busy, last_op[1:0]}.
  - 1 COUNT (R): snapshot of cnt_count.
  - 2 WRAPS (R): wrap_cnt, 32-bit, saturating at 0xFFFFFFFF.
  - 3 STATUS (R): {29'b0, wrap, err, running}. Writing 1 to bit1 or bit2 clears err or wrap. Bit0 is read-only.
- FSM states: IDLE, PULSE, SETTLE, RDWAIT.
- IDLE:
  - Write to addr0 with a legal opcode: drive cnt_command=opcode, cnt_enable=1, go to PULSE. waitrequest=1 combinationally while write is high in IDLE.
  - Opcode 3: set err, no pulse, complete in 0 wait cycles.
  - Write to addr 1 or 2: ignored, completes immediately.
  - Read of addr1: capture snapshot<=cnt_count, go to RDWAIT with waitrequest=1.
  - Other reads: readdata valid with waitrequest=0, same cycle (combinational mux, registered output not required).
- PULSE:
  - cnt_enable is high for exactly one clk cycle, so the counter sees it at one falling edge.
  - Next cycle: cnt_enable=0, cnt_command holds its value, go to SETTLE with count SETTLE.
  - Update running: START->1, STOP->0, CLEAR->unchanged. Store last_op.
- SETTLE: decrement; at 0 deassert waitrequest and return to IDLE. Total write latency is 2+SETTLE cycles.
- RDWAIT: readdata=snapshot, waitrequest=0 for one cycle, then IDLE. COUNT read latency is 1 wait cycle.
- Wrap detection:
  - Keep prev_count, updated every cycle.
  - If running=1, not in PULSE/SETTLE for CLEAR, and cnt_count < prev_count: wrap<=1 and wrap_cnt increments.
  - CLEAR also zeroes wrap_cnt.
- Simultaneous read and write: write has priority; the read is treated as not issued.
- Bus strobes arriving while busy are held off by waitrequest. The master must keep them stable, per Avalon rules.

Decomposition:
- Shared package clock_counter_pkg holds:
  - Opcode constants OP_CLEAR=0, OP_START=1, OP_STOP=2.
  - Register address constants REG_CMD=0, REG_COUNT=1, REG_WRAPS=2, REG_STATUS=3.
  - FSM state encoding.
- The counter is updated so it decodes the same opcode constants.
- No sub-module needed; the wrap detector is small enough to stay inline.

Test Plan:
- Reset mid-PULSE (assert reset_n=0 while cnt_enable=1) -> cnt_enable=0, waitrequest=0, STATUS=0 immediately, without waiting for a clock edge.
- Write CMD=1 (START), SETTLE=1 -> cnt_enable high exactly 1 cycle with cnt_command=1, waitrequest high 3 cycles, STATUS.running=1.
- START, wait 100 cycles, read COUNT -> one wait cycle, readdata within 100±3. Then STOP and read twice 20 cycles apart -> equal values.
- Write CMD=3 -> no cnt_enable pulse, STATUS=0x2. Write STATUS=0x2 -> STATUS=0x0.
- Counter model preloaded to 0xFFFFFFF0 and running -> after wrap, STATUS.wrap=1 and WRAPS=1. CLEAR -> WRAPS=0, no extra wrap counted.
- Read and write asserted together on addr0 with opcode 2 -> the STOP pulse is issued, no readdata is returned, running=0.
